// File: rtl/debounce_multi.sv
// Multi-channel button debouncer with press/release edge pulses and long-press detection.
// Every channel has its own synchroniser, stability counter and hold counter.
module debounce_multi #(
   parameter int CHANNELS      = 4,
   parameter int STABLE_CYCLES = 32,
   parameter int LONG_CYCLES   = 50000,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] button_in,
   output logic [CHANNELS-1:0] button_out,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] long_pulse,
   output logic [CHANNELS-1:0] long_hold
);

   localparam int CW = $clog2(STABLE_CYCLES);
   localparam int HW = 24;
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] LONG_MAX    = HW'(LONG_CYCLES);

   generate
      if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
         $fatal(1, "debounce_multi: CHANNELS must be 1..32");
      end
      if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable
         $fatal(1, "debounce_multi: STABLE_CYCLES must be 2..65535");
      end
      if (LONG_CYCLES <= STABLE_CYCLES || LONG_CYCLES > 16777215) begin : g_bad_long
         $fatal(1, "debounce_multi: LONG_CYCLES must exceed STABLE_CYCLES and fit in 24 bits");
      end
   endgenerate

   logic [CHANNELS-1:0] raw_in;
   logic [CHANNELS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [CHANNELS-1:0] button_out_q, button_out_d;
   logic [CHANNELS-1:0] press_pulse_q, press_pulse_d;
   logic [CHANNELS-1:0] release_pulse_q, release_pulse_d;
   logic [CHANNELS-1:0] long_pulse_q, long_pulse_d;
   logic [CHANNELS-1:0] long_hold_q, long_hold_d;
   logic [CW-1:0]       cnt_q  [CHANNELS];
   logic [CW-1:0]       cnt_d  [CHANNELS];
   logic [HW-1:0]       hold_q [CHANNELS];
   logic [HW-1:0]       hold_d [CHANNELS];

   // Inversion happens ahead of the synchroniser so a reset value of 0 is "released".
   assign raw_in = ACTIVE_LOW ? ~button_in : button_in;

   always_comb begin
      sync1_d = raw_in;
      sync2_d = sync1_q;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         button_out_d[ch]    = button_out_q[ch];
         cnt_d[ch]           = '0;
         press_pulse_d[ch]   = 1'b0;
         release_pulse_d[ch] = 1'b0;
         long_pulse_d[ch]    = 1'b0;
         long_hold_d[ch]     = long_hold_q[ch];
         hold_d[ch]          = hold_q[ch];

         if (sync2_q[ch] != button_out_q[ch]) begin
            if (cnt_q[ch] == STABLE_LAST) begin
               button_out_d[ch]    = sync2_q[ch];
               press_pulse_d[ch]   = sync2_q[ch];
               release_pulse_d[ch] = ~sync2_q[ch];
            end else begin
               cnt_d[ch] = cnt_q[ch] + CW'(1);
            end
         end

         if (!button_out_q[ch]) begin
            hold_d[ch] = '0;
         end else if (hold_q[ch] != LONG_MAX) begin
            hold_d[ch] = hold_q[ch] + HW'(1);
         end

         // An accepted release on the same edge suppresses the long-press event.
         if (release_pulse_d[ch]) begin
            long_hold_d[ch] = 1'b0;
         end else if (button_out_q[ch] && hold_q[ch] == LONG_LAST) begin
            long_pulse_d[ch] = 1'b1;
            long_hold_d[ch]  = 1'b1;
         end
      end
   end

   // NOTE: state updates use <= so every flop samples pre-edge values; the counter
   // arrays are reset explicitly because abandoned counts must not survive a reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q         <= '0;
         sync2_q         <= '0;
         button_out_q    <= '0;
         press_pulse_q   <= '0;
         release_pulse_q <= '0;
         long_pulse_q    <= '0;
         long_hold_q     <= '0;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_q[ch]  <= '0;
            hold_q[ch] <= '0;
         end
      end else begin
         sync1_q         <= sync1_d;
         sync2_q         <= sync2_d;
         button_out_q    <= button_out_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         long_pulse_q    <= long_pulse_d;
         long_hold_q     <= long_hold_d;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_q[ch]  <= cnt_d[ch];
            hold_q[ch] <= hold_d[ch];
         end
      end
   end

   assign button_out    = button_out_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign long_pulse    = long_pulse_q;
   assign long_hold     = long_hold_q;

endmodule
